ascii_decimal_parser: RTL and testbench

Receive-side counterpart of the digit-to-ASCII encoder. Consumes the byte stream from the UART receiver, converts ASCII decimal digits back to binary, and accumulates a multi-digit unsigned number. Emits the number plus its terminating character when a non-digit byte arrives. Sits between the UART RX and the ALU/interface control logic.

---
 rtl/ascii_decimal_parser_pkg.sv | 22 ++
 rtl/ascii_digit_decode.sv | 16 +
 rtl/ascii_decimal_parser.sv | 170 +++++++++++++++++
 tb/tb_ascii_decimal_parser.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ascii_decimal_parser_pkg.sv
// Shared ASCII constants and parser state encoding for the receive path.
// Included by ascii_digit_decode and ascii_decimal_parser.
package ascii_decimal_parser_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCUM   = 2'b01,
    DISCARD = 2'b10
  } state_e;

  function automatic logic is_ascii_digit(
    input logic [7:0] b
  );
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// ASCII '0'..'9' to 4-bit binary; exact inverse of the digit encoder.
// Non-digit bytes yield is_digit_o=0 and value_o=0.
module ascii_digit_decode
  import ascii_decimal_parser_pkg::*;
(
  input  logic [7:0] data_i,
  output logic       is_digit_o,
  output logic [3:0] value_o
);

  assign is_digit_o = is_ascii_digit(data_i);

  // '0'..'9' are 0x30..0x39, so the low nibble is the value
  assign value_o = is_digit_o ? data_i[3:0] : 4'd0;

endmodule

// File: rtl/ascii_decimal_parser.sv
// ASCII decimal number parser: digits accumulate, any non-digit terminates.
// Define ASCII_DECIMAL_NEG_SIGN_EN to accept a leading '-' (signed range).
module ascii_decimal_parser
  import ascii_decimal_parser_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] num,
  output logic [7:0]        term_char,
  output logic              num_valid,
  output logic              err
);

  localparam int AW = DATA_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 2);

  localparam logic [AW-1:0] LIM_U =
    AW'((64'd1 << DATA_W) - 64'd1);
  localparam logic [AW-1:0] LIM_SP =
    AW'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic [AW-1:0] LIM_SN =
    AW'(64'd1 << (DATA_W - 1));

  state_e            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic [7:0]        term_q, term_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              is_dig;
  logic [3:0]        dig_val;
  logic [AW-1:0]     acc_mul;
  logic [CW-1:0]     cnt_inc;
  logic [AW-1:0]     lim;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] res;
  logic              empty_term;
  logic              ovf;

  ascii_digit_decode u_dec (
    .data_i     (rx_data),
    .is_digit_o (is_dig),
    .value_o    (dig_val)
  );

  assign acc_mul = (acc_q << 3) + (acc_q << 1) + AW'(dig_val);
  assign cnt_inc = cnt_q + CW'(1);
  assign mag     = acc_q[DATA_W-1:0];

`ifdef ASCII_DECIMAL_NEG_SIGN_EN
  logic neg_q, neg_d;

  assign lim        = neg_q ? LIM_SN : LIM_SP;
  assign res        = neg_q ? (~mag + 1'b1) : mag;
  assign empty_term = (cnt_q == '0);
`else
  logic unused_lim;

  assign unused_lim = ^{LIM_SP, LIM_SN};
  assign lim        = LIM_U;
  assign res        = mag;
  assign empty_term = 1'b0;
`endif

  assign ovf = (acc_mul > lim) || (cnt_inc > CW'(MAX_DIGITS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    term_d  = term_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef ASCII_DECIMAL_NEG_SIGN_EN
    neg_d   = neg_q;
`endif
    if (rx_done) begin
      unique case (state_q)
        IDLE: begin
          if (is_dig) begin
            acc_d   = AW'(dig_val);
            cnt_d   = CW'(1);
            state_d = ACCUM;
          end
`ifdef ASCII_DECIMAL_NEG_SIGN_EN
          else if (rx_data == ASCII_MINUS) begin
            neg_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end
`endif
        end
        ACCUM: begin
          if (is_dig) begin
            if (ovf) begin
              state_d = DISCARD;
            end else begin
              acc_d = acc_mul;
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
`ifdef ASCII_DECIMAL_NEG_SIGN_EN
            neg_d   = 1'b0;
`endif
            // a bare '-' carries no digits and is rejected
            if (empty_term) begin
              err_d = 1'b1;
            end else begin
              num_d   = res;
              term_d  = rx_data;
              valid_d = 1'b1;
            end
          end
        end
        DISCARD: begin
          if (!is_dig) begin
            state_d = IDLE;
            err_d   = 1'b1;
`ifdef ASCII_DECIMAL_NEG_SIGN_EN
            neg_d   = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      term_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ASCII_DECIMAL_NEG_SIGN_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      term_q  <= term_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef ASCII_DECIMAL_NEG_SIGN_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign num       = num_q;
  assign term_char = term_q;
  assign num_valid = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ascii_decimal_parser.sv
// Scoreboard bench for ascii_decimal_parser.
// Honours ASCII_DECIMAL_NEG_SIGN_EN for the sign cases.
module tb_ascii_decimal_parser;

`ifdef ASCII_DECIMAL_NEG_SIGN_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] num;
  logic [7:0] term_char;
  logic       num_valid;
  logic       err;

  ascii_decimal_parser #(
    .DATA_W     (8),
    .MAX_DIGITS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .num       (num),
    .term_char (term_char),
    .num_valid (num_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int num;
    int term;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc;
  int   n_chk;
  int   n_fail;

  int   m_mode;
  int   m_val;
  int   m_cnt;
  bit   m_neg;
  int   m_num;
  int   m_term;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (num_valid === 1'b1 || err === 1'b1) begin
      if (num_valid === 1'b1 && err === 1'b1)
        chk("both_pulses", 32'd1, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexp_pulse", {30'd0, num_valid, err}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("kind_err", {31'd0, err}, {31'd0, e.is_err});
        chk("num", {24'd0, num}, e.num);
        chk("term", {24'd0, term_char}, e.term);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic push(input bit is_err);
    exp_t x;
    x.is_err = is_err;
    x.num    = m_num;
    x.term   = m_term;
    x.cyc    = cyc + 1;
    sbq.push_back(x);
  endtask

  task automatic model_clr();
    m_mode = 0; m_val = 0; m_cnt = 0;
    m_neg  = 1'b0; m_num = 0; m_term = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit d;
    int dv;
    int lim;
    d   = (b >= 8'h30) && (b <= 8'h39);
    dv  = int'(b) - 48;
    lim = NEG_EN ? (m_neg ? 128 : 127) : 255;
    case (m_mode)
      0: begin
        if (d) begin
          m_val = dv; m_cnt = 1; m_mode = 1;
        end else if (NEG_EN && b == 8'h2D) begin
          m_val = 0; m_cnt = 0; m_neg = 1'b1; m_mode = 1;
        end
      end
      1: begin
        if (d) begin
          m_val = m_val * 10 + dv;
          m_cnt++;
          if (m_cnt > 3 || m_val > lim) m_mode = 2;
        end else begin
          if (m_cnt == 0) begin
            push(1'b1);
          end else begin
            m_num  = m_neg ? ((256 - m_val) & 255) : m_val;
            m_term = int'(b);
            push(1'b0);
          end
          m_mode = 0; m_neg = 1'b0;
        end
      end
      default: begin
        if (!d) begin
          push(1'b1);
          m_mode = 0; m_neg = 1'b0;
        end
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    model_byte(b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send(s[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    model_clr();
    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    idle(3);
    reset = 1'b0;
    chk("rst_num", {24'd0, num}, 32'd0);
    chk("rst_term", {24'd0, term_char}, 32'd0);
    chk("rst_valid", {31'd0, num_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    send_str("123", 1); send(8'h0D, 1); idle(2);
    chk("t1_num", {24'd0, num}, m_num);

    send_str("255+", 1); idle(2);
    send_str("256+", 1); idle(2);
    chk("t2_hold", {24'd0, num}, m_num);

    send_str("1234", 0); send(8'h0D, 0);
    send_str("7", 0); send(8'h0D, 0);
    send_str("007", 0); send(8'h0D, 0);
    idle(2);

    send_str(" x", 1); send(8'h0D, 1); idle(2);
    chk("t4_num", {24'd0, num}, m_num);
    chk("t4_term", {24'd0, term_char}, m_term);

    send_str("45", 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    model_clr();
    chk("t5_rst_num", {24'd0, num}, 32'd0);
    send_str("6", 1); send(8'h0D, 1); idle(2);

    send_str("12-3", 0); send(8'h0D, 0); idle(2);
    send_str("099", 0); send(8'h2C, 0); idle(2);

    send_str("-128", 1); send(8'h0D, 1); idle(2);
    send_str("-129", 1); send(8'h0D, 1); idle(2);
    send_str("-", 1); send(8'h0D, 1); idle(2);
    send_str("-5", 1); send(8'h0D, 1); idle(2);
    send_str("127", 0); send(8'h0D, 0); idle(3);
    chk("final_num", {24'd0, num}, m_num);
    chk("final_term", {24'd0, term_char}, m_term);

    chk("sb_drained", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
